debug_uart_tx: RTL
==================

// Module: debug_uart_tx
// PURPOSE
//   Downstream consumer of the CPU's 64-bit debug_out register-file tap. Detects every
//   change of the debug value and queues it in a small FIFO. Serialises each queued word
//   as 8 UART bytes: 8N1 framing, little-endian byte order, each byte sent LSB first.
//   Gives bench/board observation of program results without stopping the core.
// PARAMETERS
//   CLKS_PER_BIT  868  clk cycles per UART bit period; legal range >= 2
//   FIFO_DEPTH    4    number of queued 64-bit words; power of two, >= 2
// PORTS
//   clk         in   1                          system clock; all logic on rising edge
//   rst         in   1                          synchronous reset, active-high
//   debug_in    in   64                         CPU debug_out value
//   tx          out  1                          UART serial line; idles high
//   busy        out  1                          1 while a word is being serialised
//   overflow    out  1                          sticky: a change was dropped because the FIFO was full
//   fifo_count  out  $clog2(FIFO_DEPTH+1)       words currently queued (excludes word in shifter)
// BEHAVIOUR
//   Reset values: tx=1, busy=0, overflow=0, fifo_count=0, FSM=IDLE, prev_q=0, FIFO empty.
//   Reset mid-frame: line returns high at the next edge; queued and in-flight words are
//   discarded; no partial frame is resumed.
//   Change detect:
//     - prev_q <= debug_in every cycle.
//     - push = (debug_in != prev_q); push takes effect at the same edge.
//     - debug_in = 0 directly after reset does not push.
//   FIFO:
//     - push accepted if fifo_count < FIFO_DEPTH, or if a pop occurs in the same cycle.
//     - Otherwise the word is dropped and overflow <= 1, held until rst.
//     - Simultaneous push+pop leaves fifo_count unchanged.
//     - Read/write pointers wrap modulo FIFO_DEPTH.
//   FSM states: IDLE, START, DATA, STOP.
//     - IDLE: tx=1. If fifo_count != 0, pop the head into shift_q[63:0] and set byte_idx=0;
//       goes to START at the same edge. The start bit therefore appears on tx 1 cycle
//       after the pop edge.
//     - START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit_idx=0.
//     - DATA: tx=shift_q[byte_idx*8+bit_idx] for CLKS_PER_BIT cycles per bit, 8 bits,
//       then STOP.
//     - STOP: tx=1 for CLKS_PER_BIT cycles. Then:
//         byte_idx<7  -> byte_idx++ and go to START (no extra idle gap);
//         byte_idx==7 -> go to IDLE.
//   Timing and flags:
//     - baud counter counts 0..CLKS_PER_BIT-1 and resets on every state/bit change.
//     - busy = (state != IDLE). busy is 1 for exactly 80*CLKS_PER_BIT cycles per word.
//     - Back-to-back words: IDLE lasts exactly 1 cycle between frames when the FIFO is
//       non-empty.
//     - tx is driven from a register (glitch-free); the start of a frame aligns to a clk edge.
//   debug_in changes while busy are queued, not lost, up to the FIFO_DEPTH limit.
// TESTING (CLKS_PER_BIT=4, FIFO_DEPTH=4)
//   1. Reset, debug_in held 0 for 100 cycles -> tx=1, busy=0, fifo_count=0 throughout.
//   2. debug_in 0 -> 64'h0123456789ABCDEF -> one 320-cycle frame decoding to bytes
//      EF CD AB 89 67 45 23 01. Each byte has start=0 and stop=1. Then busy=0.
//   3. debug_in takes six distinct values on six consecutive cycles -> 5 words transmitted
//      in order, 6th dropped, overflow=1, fifo_count peaks at 4.
//   4. Two changes 10 cycles apart -> second word's start bit begins exactly 1 cycle after
//      the first word's final stop bit ends.
//   5. Assert rst during byte 3 of a frame with 2 words queued -> next cycle tx=1, busy=0,
//      fifo_count=0, overflow=0. No further bytes are sent.
//   6. debug_in toggles A->B->A -> three words are sent (A, B, A). An unchanged value
//      produces no push.

Source files
------------

// File: rtl/debug_uart_tx.sv
// Debug tap serialiser: queues every change of the 64-bit debug value and sends it
// as 8 UART 8N1 bytes, least-significant byte first, each byte LSB first.
module debug_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [63:0]                       debug_in,
    output logic                              tx,
    output logic                              busy,
    output logic                              overflow,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);
    // state | meaning
    // IDLE  | line high, waiting for a queued word
    // START | start bit (low)
    // DATA  | 8 data bits of the current byte
    // STOP  | stop bit (high), then next byte or IDLE
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT);

    state_t          state_q, state_d;
    logic [BW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [2:0]      byte_idx_q, byte_idx_d;
    logic [63:0]     shift_q, shift_d;
    logic            tx_q, tx_d;
    logic [63:0]     prev_q, prev_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic            overflow_q, overflow_d;
    logic [63:0]     mem_q [FIFO_DEPTH];

    logic push, pop, accept, baud_last;

    always_comb begin
        push       = (debug_in != prev_q);
        pop        = (state_q == IDLE) && (count_q != '0);
        accept     = push && ((count_q < CW'(FIFO_DEPTH)) || pop);
        prev_d     = debug_in;
        overflow_d = overflow_q | (push & ~accept);
        wr_ptr_d   = accept ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d    = count_q;
        if (accept && !pop)
            count_d = count_q + CW'(1);
        else if (pop && !accept)
            count_d = count_q - CW'(1);
    end

    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q + BW'(1);
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        shift_d    = shift_q;
        tx_d       = 1'b1;
        baud_last  = (baud_q == BW'(CLKS_PER_BIT - 1));
        // tx follows the current state one cycle later, so the line is purely registered
        unique case (state_q)
            IDLE: begin
                baud_d = '0;
                if (pop) begin
                    state_d    = START;
                    shift_d    = mem_q[rd_ptr_q];
                    byte_idx_d = '0;
                    bit_idx_d  = '0;
                end
            end
            START: begin
                tx_d = 1'b0;
                if (baud_last) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                    baud_d    = '0;
                end
            end
            DATA: begin
                tx_d = shift_q[{byte_idx_q, bit_idx_q}];
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_idx_q == 3'd7)
                        state_d = STOP;
                    else
                        bit_idx_d = bit_idx_q + 3'd1;
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (byte_idx_q == 3'd7) begin
                        state_d = IDLE;
                    end else begin
                        byte_idx_d = byte_idx_q + 3'd1;
                        state_d    = START;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            prev_q     <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            prev_q     <= prev_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && accept)
            mem_q[wr_ptr_q] <= debug_in;
    end

    assign tx         = tx_q;
    assign busy       = (state_q != IDLE);
    assign overflow   = overflow_q;
    assign fifo_count = count_q;
endmodule
